sha256d_nonce_verifier: RTL
===========================

# sha256d_nonce_verifier

Iterative double-SHA-256 checker that re-hashes a candidate nonce from the unrolled miner pipeline. It confirms that the nonce meets the difficulty target before the result is reported upstream. It receives the midstate, the 96-bit header tail and the nonce, then runs both compressions one round per cycle, and returns the final hash plus a pass/fail flag. It costs about 1/64 of one unrolled hasher and is the independent second opinion on every golden nonce.

## Interface
- `DIFFICULTY`, default 4: number of leading hash bits (`hash[255 -: DIFFICULTY]`) that must be zero; legal range 1..256.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  candidate present.
- `in_ready`  out  1  block can accept a candidate; high only in IDLE.
- `in_midstate`  in  256  state after header block 1; word a at [31:0] … word h at [255:224].
- `in_tail`  in  96  first three words of header block 2.
- `in_nonce`  in  32  candidate nonce.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer accepts the result.
- `out_hash`  out  256  final SHA-256d state, same word packing as `in_midstate`.
- `out_nonce`  out  32  echoed nonce.
- `out_golden`  out  1  the difficulty check passed.

## Operation
- **Block 1.** The 512-bit message is `{384'h000002800000000000000000000000000000000000000000000000000000000000000000000000000000000080000000, in_nonce, in_tail}`. Word 0 is at [31:0]. Initial state is `in_midstate`.
- **Block 2.** The message is `{256'h0000010000000000000000000000000000000000000000000000000080000000, H1}`. Initial state is the IV `256'h5be0cd191f83d9ab9b05688c510e527fa54ff53a3c6ef372bb67ae856a09e667`.
- **Round r (0..63).** Uses constant `K[r]`, with `K[0]=32'h428a2f98` through `K[63]=32'hc67178f2`.
  - t1 = h + Σ1(e) + Ch(e,f,g) + w[0] + K[r]
  - t2 = Σ0(a) + Maj(a,b,c)
  - The state shifts: new e = d + t1, new a = t1 + t2.
  - The window shifts down one word; the new w[15] = σ1(w[14]) + w[9] + σ0(w[1]) + w[0].
- **Finalisation.** H = initial state + round-63 state, added per 32-bit word mod 2^32.
  - H1 (block-1 result) feeds block 2.
  - H2 (block-2 result) drives `out_hash`.
- **Difficulty.** `out_golden = (H2[255 -: DIFFICULTY] == 0)`.
- **FSM states:**
  - IDLE: `in_ready=1`. On `in_valid`, latch the inputs, load the block-1 window and state, clear the round counter, go to R1.
  - R1: 64 cycles, rounds 0..63. When the counter reaches 63, go to F1.
  - F1: 1 cycle. Compute H1, load the block-2 window and IV, clear the counter, go to R2.
  - R2: 64 cycles. When the counter reaches 63, go to F2.
  - F2: 1 cycle. Register `out_hash`, `out_nonce` and `out_golden`, set `out_valid`, go to HOLD.
  - HOLD: outputs are stable while `out_valid=1`. On `out_ready`, clear `out_valid` and go to IDLE.
- **Round counter.** 6 bits; it wraps 63→0 only via the explicit clear.
- **Width rule.** All additions are 32-bit and carries are discarded.

## Timing
- **Reset:** state IDLE, counter 0. `in_ready` reads 1 after reset. `out_valid`, `out_golden`, `out_hash` and `out_nonce` all reset to 0.
- **Latency:** input accepted at edge T → `out_valid` high after edge T+130 (R1 ends at T+64, F1 at T+65, R2 ends at T+129, F2 at T+130).
- **Backpressure:** HOLD lasts indefinitely while `out_ready=0`, with outputs frozen.
- **After the output handshake:** a handshake at edge U gives `in_ready=1` from U+1. There is no accept in the same cycle as an output handshake.
- **Throughput:** at most one candidate per 132 cycles with `out_ready` tied high.
- **Inputs:** `in_*` are don't-care outside IDLE; `in_valid` outside IDLE is ignored, not queued.
- **Reset mid-operation:** reset in any state discards the job; the block is in IDLE with outputs cleared on the next cycle. Reset wins over any simultaneous handshake.

## Structure
- **Package `sha256_pkg`** holds:
  - the K[0:63] constant array;
  - the IV constant;
  - the block-1 and block-2 padding constants;
  - the FSM state enum;
  - the word and state width constants.
- **Sub-module `sha256_round`** (combinational): inputs state[255:0], w[511:0], k[31:0]; outputs next state and next window. It reuses the existing e0/e1/ch/maj/s0/s1 function blocks.
- **Top level** holds the FSM, the counter, the saved initial state for finalisation, and the output registers.

## Test plan
- **Reference run:** `in_midstate` = IV, `in_tail` = 0, `in_nonce` = `32'h00000000`, `out_ready` = 1 → `out_valid` exactly 130 cycles after accept. `out_hash` matches a software SHA-256d model; `out_nonce` = 0.
- **Backpressure:** as above, with `out_ready` held 0 for 50 cycles → outputs unchanged for 50 cycles and `in_ready` stays 0. Release → handshake, `in_ready` = 1 the next cycle.
- **Difficulty sweep:** nonces 0..255 at `DIFFICULTY=4` → `out_golden` agrees with the model for every nonce, including at least one pass. The same nonces at `DIFFICULTY=256` → `out_golden=0` for all.
- **Reset mid-job:** assert `rst` at cycle 70 of a job → all outputs 0 and `in_ready=1` next cycle. A fresh job then completes correctly after 130 cycles.
- **Inputs ignored while busy:** toggle `in_valid`/`in_nonce` randomly during R1/R2 → the result reflects only the latched nonce.
- **Back-to-back jobs:** with `out_ready=1`, two candidates queued back-to-back → accepted 132 cycles apart, with both results correct.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM encoding and round helper functions for the nonce verifier.
package sha256_pkg;

    localparam int WORD_W  = 32;
    localparam int STATE_W = 256;
    localparam int BLOCK_W = 512;
    localparam int TAIL_W  = 96;
    localparam int PAD1_W  = 384;
    localparam int PAD2_W  = 256;
    localparam int CNT_W   = 6;

    localparam logic [CNT_W-1:0] LAST_ROUND = 6'd63;

    localparam logic [STATE_W-1:0] IV =
        256'h5be0cd19_1f83d9ab_9b05688c_510e527f_a54ff53a_3c6ef372_bb67ae85_6a09e667;

    // Header block 2 padding: 0x80 marker after the nonce, 640-bit length in word 15.
    localparam logic [PAD1_W-1:0] PAD1 =
        384'h00000280_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_80000000;

    // Second pass hashes the 256-bit digest: marker in word 8, length 256 in word 15.
    localparam logic [PAD2_W-1:0] PAD2 =
        256'h00000100_00000000_00000000_00000000_00000000_00000000_00000000_80000000;

    localparam logic [WORD_W-1:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_R1,
        ST_F1,
        ST_R2,
        ST_F2,
        ST_HOLD
    } fsm_e;

    function automatic logic [WORD_W-1:0] e0(input logic [WORD_W-1:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [WORD_W-1:0] e1(input logic [WORD_W-1:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [WORD_W-1:0] s0(input logic [WORD_W-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [WORD_W-1:0] s1(input logic [WORD_W-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    function automatic logic [WORD_W-1:0] ch(input logic [WORD_W-1:0] x, input logic [WORD_W-1:0] y,
                                             input logic [WORD_W-1:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [WORD_W-1:0] maj(input logic [WORD_W-1:0] x, input logic [WORD_W-1:0] y,
                                              input logic [WORD_W-1:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    // Word-wise mod-2^32 sum used to fold the round output back onto the chaining value.
    function automatic logic [STATE_W-1:0] add_state(input logic [STATE_W-1:0] x,
                                                     input logic [STATE_W-1:0] y);
        logic [STATE_W-1:0] r;
        r = '0;
        for (int i = 0; i < STATE_W / WORD_W; i++) begin
            r[i*WORD_W +: WORD_W] = x[i*WORD_W +: WORD_W] + y[i*WORD_W +: WORD_W];
        end
        return r;
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round plus message-window advance; zero latency, no flow control.
// State word a sits at [31:0]; window word 0 (the word consumed this round) at [31:0].
module sha256_round
    import sha256_pkg::*;
(
    input  logic [STATE_W-1:0] state_i,
    input  logic [BLOCK_W-1:0] w_i,
    input  logic [WORD_W-1:0]  k_i,
    output logic [STATE_W-1:0] state_o,
    output logic [BLOCK_W-1:0] w_o
);

    logic [WORD_W-1:0] a, b, c, d, e, f, g, h;
    logic [WORD_W-1:0] t1, t2, w_new;

    always_comb begin
        a = state_i[0*WORD_W +: WORD_W];
        b = state_i[1*WORD_W +: WORD_W];
        c = state_i[2*WORD_W +: WORD_W];
        d = state_i[3*WORD_W +: WORD_W];
        e = state_i[4*WORD_W +: WORD_W];
        f = state_i[5*WORD_W +: WORD_W];
        g = state_i[6*WORD_W +: WORD_W];
        h = state_i[7*WORD_W +: WORD_W];

        t1 = h + e1(e) + ch(e, f, g) + w_i[0 +: WORD_W] + k_i;
        t2 = e0(a) + maj(a, b, c);

        state_o = {g, f, e, d + t1, c, b, a, t1 + t2};

        // Window holds W[r..r+15]; append W[r+16] and drop W[r].
        w_new = s1(w_i[14*WORD_W +: WORD_W]) + w_i[9*WORD_W +: WORD_W]
              + s0(w_i[1*WORD_W +: WORD_W]) + w_i[0 +: WORD_W];
        w_o   = {w_new, w_i[BLOCK_W-1:WORD_W]};
    end

endmodule

// File: rtl/sha256d_nonce_verifier.sv
// Iterative SHA-256d re-check of a candidate nonce: accept at edge T, out_valid after edge T+130.
// Single job in flight: in_ready only in IDLE; the result is held indefinitely until out_ready.
module sha256d_nonce_verifier
    import sha256_pkg::*;
#(
    parameter int DIFFICULTY = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_midstate,
    input  logic [TAIL_W-1:0]  in_tail,
    input  logic [WORD_W-1:0]  in_nonce,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_hash,
    output logic [WORD_W-1:0]  out_nonce,
    output logic               out_golden
);

    fsm_e               state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STATE_W-1:0] work_q, work_d;
    logic [BLOCK_W-1:0] win_q, win_d;
    logic [STATE_W-1:0] init_q, init_d;
    logic [WORD_W-1:0]  nonce_q, nonce_d;
    logic               valid_q, valid_d;
    logic [STATE_W-1:0] hash_q, hash_d;
    logic [WORD_W-1:0]  onon_q, onon_d;
    logic               golden_q, golden_d;

    logic [STATE_W-1:0] rnd_state;
    logic [BLOCK_W-1:0] rnd_win;
    logic [STATE_W-1:0] fin;
    logic               fin_golden;

    sha256_round u_round (
        .state_i (work_q),
        .w_i     (win_q),
        .k_i     (K[cnt_q]),
        .state_o (rnd_state),
        .w_o     (rnd_win)
    );

    assign fin        = add_state(init_q, work_q);
    assign fin_golden = (fin[STATE_W-1 -: DIFFICULTY] == '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        win_d    = win_q;
        init_d   = init_q;
        nonce_d  = nonce_q;
        valid_d  = valid_q;
        hash_d   = hash_q;
        onon_d   = onon_q;
        golden_d = golden_q;
        in_ready = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    work_d  = in_midstate;
                    init_d  = in_midstate;
                    win_d   = {PAD1, in_nonce, in_tail};
                    nonce_d = in_nonce;
                    cnt_d   = '0;
                    state_d = ST_R1;
                end
            end
            ST_R1, ST_R2: begin
                work_d = rnd_state;
                win_d  = rnd_win;
                if (cnt_q == LAST_ROUND) begin
                    state_d = (state_q == ST_R1) ? ST_F1 : ST_F2;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_F1: begin
                // Block-1 digest becomes the message of the second pass.
                work_d  = IV;
                init_d  = IV;
                win_d   = {PAD2, fin};
                cnt_d   = '0;
                state_d = ST_R2;
            end
            ST_F2: begin
                hash_d   = fin;
                onon_d   = nonce_q;
                golden_d = fin_golden;
                valid_d  = 1'b1;
                state_d  = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            work_q   <= '0;
            win_q    <= '0;
            init_q   <= '0;
            nonce_q  <= '0;
            valid_q  <= 1'b0;
            hash_q   <= '0;
            onon_q   <= '0;
            golden_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            win_q    <= win_d;
            init_q   <= init_d;
            nonce_q  <= nonce_d;
            valid_q  <= valid_d;
            hash_q   <= hash_d;
            onon_q   <= onon_d;
            golden_q <= golden_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_hash   = hash_q;
    assign out_nonce  = onon_q;
    assign out_golden = golden_q;

endmodule
